// File: rtl/button_latch_bank_pkg.sv
// rtl/button_latch_bank_pkg.sv - shared state encodings and helpers for the button latch bank
package button_latch_bank_pkg;

  localparam int unsigned DEF_N_CH            = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

  // UP/DN records whether the FSM has seen the debounced button pressed.
  // S_HOLD parks a channel that was cleared while its button was still down.
  typedef enum logic [2:0] {
    S_OFF_UP = 3'd0,
    S_OFF_DN = 3'd1,
    S_ON_UP  = 3'd2,
    S_ON_DN  = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  function automatic logic is_on(input state_e s);
    return (s == S_ON_UP) || (s == S_ON_DN);
  endfunction

  // Counter must hold 0..cycles-1; keep at least one bit so zero-width vectors never appear.
  function automatic int cnt_width(input int unsigned cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/button_latch_chan.sv
// rtl/button_latch_chan.sv - one channel: synchroniser, debouncer and toggle-latch FSM
module button_latch_chan
  import button_latch_bank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          TOGGLE_ON_PRESS = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clr,
  output logic latch,
  output logic toggle_pulse,
  output logic db_level
);

  logic s1_q;
  logic s2_q;
  logic db;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign db = s2_q;
    end else begin : g_debounce
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          db_q;
      logic          db_d;

      // Accept a new level only after it has differed from db for DEBOUNCE_CYCLES cycles in a row.
      always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s2_q == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          db_d  = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Debounce counter and accepted level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
          db_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          db_q  <= db_d;
        end
      end

      assign db = db_q;
    end
  endgenerate

  state_e state_q;
  state_e state_d;
  logic   toggle_arc;
  logic   latch_q;
  logic   latch_d;
  logic   pulse_q;
  logic   pulse_d;

  // Next state: press mode flips on the DN-bound arc, release mode on the UP-bound arc; clr overrides.
  always_comb begin
    state_d    = state_q;
    toggle_arc = 1'b0;
    case (state_q)
      S_OFF_UP: if (db) begin
        state_d    = TOGGLE_ON_PRESS ? S_ON_DN : S_OFF_DN;
        toggle_arc = TOGGLE_ON_PRESS;
      end
      S_OFF_DN: if (!db) begin
        state_d    = TOGGLE_ON_PRESS ? S_OFF_UP : S_ON_UP;
        toggle_arc = !TOGGLE_ON_PRESS;
      end
      S_ON_UP: if (db) begin
        state_d    = TOGGLE_ON_PRESS ? S_OFF_DN : S_ON_DN;
        toggle_arc = TOGGLE_ON_PRESS;
      end
      S_ON_DN: if (!db) begin
        state_d    = TOGGLE_ON_PRESS ? S_ON_UP : S_OFF_UP;
        toggle_arc = !TOGGLE_ON_PRESS;
      end
      S_HOLD: if (!db) begin
        state_d = S_OFF_UP;
      end
      default: state_d = S_OFF_UP;
    endcase
    if (clr) begin
      state_d    = db ? S_HOLD : S_OFF_UP;
      toggle_arc = 1'b0;
    end
    latch_d = is_on(state_d);
    pulse_d = toggle_arc;
  end

  // State plus registered copies of the latch and toggle outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF_UP;
      latch_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      pulse_q <= pulse_d;
    end
  end

  assign latch        = latch_q;
  assign toggle_pulse = pulse_q;
  assign db_level     = db;

endmodule

// File: rtl/button_latch_bank.sv
// rtl/button_latch_bank.sv - N independent debounced push-button toggle latches
module button_latch_bank
  import button_latch_bank_pkg::*;
#(
  parameter int unsigned         N_CH            = DEF_N_CH,
  parameter int unsigned         DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [N_CH-1:0]     TOGGLE_ON_PRESS = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] clr,
  output logic [N_CH-1:0] latch,
  output logic [N_CH-1:0] toggle_pulse,
  output logic [N_CH-1:0] db_level
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_latch_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .TOGGLE_ON_PRESS (TOGGLE_ON_PRESS[i])
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .btn          (btn[i]),
      .clr          (clr[i]),
      .latch        (latch[i]),
      .toggle_pulse (toggle_pulse[i]),
      .db_level     (db_level[i])
    );
  end

endmodule

// File: tb/tb_button_latch_bank.sv
// tb/tb_button_latch_bank.sv - self-checking bench for button_latch_bank
module tb_button_latch_bank;

  localparam int unsigned NCH = 4;
  localparam int unsigned DC  = 4;
  localparam logic [3:0]  TOP = 4'b0010;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] clr;
  logic [3:0] latch;
  logic [3:0] toggle_pulse;
  logic [3:0] db_level;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  button_latch_bank #(
    .N_CH            (NCH),
    .DEBOUNCE_CYCLES (DC),
    .TOGGLE_ON_PRESS (TOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .clr          (clr),
    .latch        (latch),
    .toggle_pulse (toggle_pulse),
    .db_level     (db_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: pipeline of samples, a history window for debounce,
  // and a "seen level" plus hold flag describing each latch.
  logic [3:0] m_s1, m_s2, m_db, m_lvl, m_hold, m_latch, m_pulse;
  bit         m_hist [4][$];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_lvl = '0;
    m_hold = '0; m_latch = '0; m_pulse = '0;
    for (int c = 0; c < 4; c++) m_hist[c].delete();
  endtask

  task automatic model_step();
    bit all_diff;
    for (int c = 0; c < 4; c++) begin
      m_pulse[c] = 1'b0;
      if (clr[c]) begin
        m_latch[c] = 1'b0;
        m_hold[c]  = m_db[c];
        m_lvl[c]   = m_db[c];
      end else if (m_hold[c]) begin
        if (!m_db[c]) begin
          m_hold[c] = 1'b0;
          m_lvl[c]  = 1'b0;
        end
      end else if (m_db[c] != m_lvl[c]) begin
        m_lvl[c] = m_db[c];
        if (m_db[c] == TOP[c]) begin
          m_latch[c] = ~m_latch[c];
          m_pulse[c] = 1'b1;
        end
      end
      m_hist[c].push_back(m_s2[c]);
      if (m_hist[c].size() > DC) void'(m_hist[c].pop_front());
      if (m_hist[c].size() == DC) begin
        all_diff = 1'b1;
        for (int k = 0; k < m_hist[c].size(); k++)
          if (m_hist[c][k] == m_db[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[c] = ~m_db[c];
          m_hist[c].delete();
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      chk("mdl_latch", 32'(latch), 32'(m_latch));
      chk("mdl_pulse", 32'(toggle_pulse), 32'(m_pulse));
      chk("mdl_db", 32'(db_level), 32'(m_db));
    end
  end

  typedef struct {
    logic [3:0] btn;
    logic [3:0] clr;
    int         cycles;
    logic [3:0] exp_latch;
    logic [3:0] exp_db;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{4'b0010, 4'b0000, 20, 4'b0010, 4'b0010};
    tbl[1]  = '{4'b0000, 4'b0000, 20, 4'b0010, 4'b0000};
    tbl[2]  = '{4'b0010, 4'b0000, 20, 4'b0000, 4'b0010};
    tbl[3]  = '{4'b0000, 4'b0000, 20, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0100, 4'b0000,  3, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0000,  1, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b0100, 4'b0000,  3, 4'b0000, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000, 10, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b0100, 4'b0000, 10, 4'b0000, 4'b0100};
    tbl[9]  = '{4'b0000, 4'b0000, 10, 4'b0100, 4'b0000};
    tbl[10] = '{4'b0000, 4'b0100,  1, 4'b0000, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000,  5, 4'b0000, 4'b0000};

    rst = 1'b0;
    btn = 4'hF;
    clr = 4'h0;
    tick(3);
    chk("rst_latch", 32'(latch), 0);
    chk("rst_pulse", 32'(toggle_pulse), 0);
    chk("rst_db", 32'(db_level), 0);

    btn = 4'h1;
    rst = 1'b1;
    chk_en = 1'b1;
    tick(20);
    chk("hold_db", 32'(db_level), 4'h1);
    chk("hold_latch", 32'(latch), 0);

    btn = 4'h0;
    tick(6);
    chk("rel_e6_latch", 32'(latch), 0);
    chk("rel_e6_pulse", 32'(toggle_pulse), 0);
    tick(1);
    chk("rel_e7_latch", 32'(latch), 4'h1);
    chk("rel_e7_pulse", 32'(toggle_pulse), 4'h1);
    tick(1);
    chk("rel_e8_pulse", 32'(toggle_pulse), 0);
    chk("rel_e8_latch", 32'(latch), 4'h1);
    btn = 4'h1; tick(20);
    btn = 4'h0; tick(20);
    chk("rel_second", 32'(latch), 0);

    for (int i = 0; i < 12; i++) begin
      btn = tbl[i].btn;
      clr = tbl[i].clr;
      tick(tbl[i].cycles);
      chk($sformatf("vec%0d_latch", i), 32'(latch), 32'(tbl[i].exp_latch));
      chk($sformatf("vec%0d_db", i), 32'(db_level), 32'(tbl[i].exp_db));
    end
    clr = 4'h0;

    btn = 4'h1; tick(20);
    btn = 4'h0; tick(20);
    chk("clr_setup", 32'(latch), 4'h1);
    btn = 4'h1; tick(20);
    clr = 4'h1; tick(1);
    chk("clr_latch", 32'(latch), 0);
    chk("clr_pulse", 32'(toggle_pulse), 0);
    clr = 4'h0;
    btn = 4'h0; tick(20);
    chk("clr_release", 32'(latch), 0);

    btn = 4'h2; tick(6);
    chk("clr_coin_pre", 32'(latch), 0);
    clr = 4'h2; tick(1);
    chk("clr_coin_latch", 32'(latch), 0);
    chk("clr_coin_pulse", 32'(toggle_pulse), 0);
    clr = 4'h0; tick(2);
    chk("clr_coin_after", 32'(latch), 0);
    btn = 4'h0; tick(20);
    chk("clr_coin_rel", 32'(latch), 0);
    btn = 4'h2; tick(20);
    chk("clr_coin_repress", 32'(latch), 4'h2);
    btn = 4'h0; tick(20);
    chk("clr_coin_rerel", 32'(latch), 4'h2);

    btn = 4'hF; tick(20);
    chk("all_press", 32'(latch), 0);
    btn = 4'h0; tick(6);
    chk("all_rel_e6", 32'(latch), 0);
    tick(1);
    chk("all_rel_e7_latch", 32'(latch), 4'hD);
    chk("all_rel_e7_pulse", 32'(toggle_pulse), 4'hD);
    tick(1);
    chk("all_rel_e8_pulse", 32'(toggle_pulse), 0);

    btn = 4'hF; tick(3);
    #2 rst = 1'b0;
    #1;
    chk("midrst_latch", 32'(latch), 0);
    chk("midrst_pulse", 32'(toggle_pulse), 0);
    chk("midrst_db", 32'(db_level), 0);
    tick(2);
    rst = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
        clr[c] = ($urandom_range(0, 39) == 0);
      end
      if (cyc == 750) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
      tick(1);
    end

    btn = 4'h0;
    clr = 4'h0;
    tick(20);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
